// File: rtl/noc_packet_ejector_pkg.sv
// Shared NoC field layout plus ejector types and flit field helpers.
// Flit: [31:30] H marker, [29:28] E marker, [27:24] source {x,y}, [23:20] dest {x,y}.
`ifndef NOC_PARAMETERS
`define NOC_PARAMETERS
`define Noc_Data_Width 32
`define Noc_ID_X_Width 2
`define Noc_ID_Y_Width 2
`define Noc_Head_H 2'b11
`define Noc_Head_E 2'b01
`define Noc_Tail_H 2'b11
`define Noc_Tail_E 2'b10
`define Noc_Point_H 28
`define Noc_Source_Point 24
`define Noc_Point_E 20
`define Axi_Len_Point 8
`endif

package noc_packet_ejector_pkg;

    localparam int DW = `Noc_Data_Width;
    localparam int XW = `Noc_ID_X_Width;
    localparam int YW = `Noc_ID_Y_Width;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BODY    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        BODY    = ST_BODY,
        DISCARD = ST_DISCARD
    } state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          err;
        logic [XW-1:0] src_x;
        logic [YW-1:0] src_y;
    } entry_t;

    function automatic logic [1:0] h_field(input logic [DW-1:0] f);
        return f[DW-1:DW-2];
    endfunction

    function automatic logic [1:0] e_field(input logic [DW-1:0] f);
        return f[DW-3:`Noc_Point_H];
    endfunction

    function automatic logic [XW+YW-1:0] src_field(input logic [DW-1:0] f);
        return f[`Noc_Point_H-1:`Noc_Source_Point];
    endfunction

    function automatic logic [XW+YW-1:0] dst_field(input logic [DW-1:0] f);
        return f[`Noc_Source_Point-1:`Noc_Point_E];
    endfunction

endpackage

// File: rtl/noc_eject_fifo.sv
// First-word-fall-through FIFO; simultaneous push and pop allowed even when full.
module noc_eject_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/noc_packet_ejector.sv
// Local-port packet ejector: strips header/tail, stages payload to tag the last word.
module noc_packet_ejector
    import noc_packet_ejector_pkg::*;
#(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID       = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID       = '0,
    parameter int                         FIFO_DEPTH = 4
) (
    input  logic                          noc_clk,
    input  logic                          noc_rst,
    input  logic                          receive_valid,
    output logic                          receive_ready,
    input  logic [`Noc_Data_Width-1:0]    receive_flit,
    input  logic                          receive_is_header,
    input  logic                          receive_is_tail,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output logic [`Noc_Data_Width-1:0]    pkt_data,
    output logic                          pkt_last,
    output logic                          pkt_err,
    output logic [`Noc_ID_X_Width-1:0]    pkt_src_x,
    output logic [`Noc_ID_Y_Width-1:0]    pkt_src_y,
    output logic [7:0]                    err_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    state_t        state, state_n;
    logic [DW-1:0] stage, stage_n;
    logic          stage_vld, stage_vld_n;
    logic [XW-1:0] src_x_q, src_x_n;
    logic [YW-1:0] src_y_q, src_y_n;
    logic [7:0]    err_q;
    logic          err_inc;
    logic          push;
    entry_t        push_entry;
    entry_t        head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          pop;
    logic          fire;
    logic          hdr_ok;
    logic          tail_bad;

    assign pop  = !noc_rst && !empty && pkt_ready;
    assign fire = receive_valid && receive_ready;

    assign receive_ready = !noc_rst && ((state == DISCARD) || !full || pop);

    assign hdr_ok = receive_is_header
                 && h_field(receive_flit) == `Noc_Head_H
                 && e_field(receive_flit) == `Noc_Head_E
                 && dst_field(receive_flit) == {X_ID, Y_ID};

    assign tail_bad = h_field(receive_flit) != `Noc_Tail_H
                   || e_field(receive_flit) != `Noc_Tail_E
                   || src_field(receive_flit) != {src_x_q, src_y_q};

    always_comb begin
        state_n     = state;
        stage_n     = stage;
        stage_vld_n = stage_vld;
        src_x_n     = src_x_q;
        src_y_n     = src_y_q;
        err_inc     = 1'b0;
        push        = 1'b0;
        push_entry  = '{data: stage, last: 1'b0, err: 1'b0,
                        src_x: src_x_q, src_y: src_y_q};
        if (fire) begin
            unique case (state)
                IDLE, BODY: begin
                    if (receive_is_header) begin
                        // a header mid-packet aborts whatever is staged
                        if (state == BODY) begin
                            push           = stage_vld;
                            push_entry.last = 1'b1;
                            push_entry.err  = 1'b1;
                            err_inc        = 1'b1;
                        end
                        stage_vld_n = 1'b0;
                        if (hdr_ok) begin
                            {src_x_n, src_y_n} = src_field(receive_flit);
                            state_n = BODY;
                        end else begin
                            err_inc = 1'b1;
                            state_n = DISCARD;
                        end
                    end else if (state == IDLE) begin
                        err_inc = 1'b1;
                    end else if (receive_is_tail) begin
                        push            = stage_vld;
                        push_entry.last = 1'b1;
                        push_entry.err  = tail_bad;
                        err_inc         = tail_bad || !stage_vld;
                        stage_vld_n     = 1'b0;
                        state_n         = IDLE;
                    end else begin
                        push        = stage_vld;
                        stage_n     = receive_flit;
                        stage_vld_n = 1'b1;
                    end
                end
                DISCARD: begin
                    if (receive_is_tail) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state     <= IDLE;
            stage     <= '0;
            stage_vld <= 1'b0;
            src_x_q   <= '0;
            src_y_q   <= '0;
            err_q     <= '0;
        end else begin
            state     <= state_n;
            stage     <= stage_n;
            stage_vld <= stage_vld_n;
            src_x_q   <= src_x_n;
            src_y_q   <= src_y_n;
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    noc_eject_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (noc_clk),
        .rst       (noc_rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge noc_clk) begin
        if (!noc_rst) assert (full == (count == DEPTH_C));
    end

    // outputs are forced low for the whole reset, not just after the edge
    assign pkt_valid = !noc_rst && !empty;
    assign pkt_data  = noc_rst ? '0 : head.data;
    assign pkt_last  = !noc_rst && head.last;
    assign pkt_err   = !noc_rst && head.err;
    assign pkt_src_x = noc_rst ? '0 : head.src_x;
    assign pkt_src_y = noc_rst ? '0 : head.src_y;
    assign err_cnt   = noc_rst ? '0 : err_q;

endmodule

// File: tb/tb_noc_packet_ejector.sv
// Directed bench for noc_packet_ejector at node (0,0) with a 4-entry FIFO.
module tb_noc_packet_ejector;

    logic        noc_clk = 1'b0;
    logic        noc_rst = 1'b1;
    logic        receive_valid = 1'b0;
    logic        receive_ready;
    logic [31:0] receive_flit = '0;
    logic        receive_is_header = 1'b0;
    logic        receive_is_tail = 1'b0;
    logic        pkt_valid;
    logic        pkt_ready = 1'b1;
    logic [31:0] pkt_data;
    logic        pkt_last;
    logic        pkt_err;
    logic [1:0]  pkt_src_x;
    logic [1:0]  pkt_src_y;
    logic [7:0]  err_cnt;

    localparam logic [31:0] HDR      = 32'hD600_0000;
    localparam logic [31:0] HDR_BAD  = 32'hD6F0_0000;
    localparam logic [31:0] TAIL     = 32'hE600_0000;
    localparam logic [31:0] TAIL_BAD = 32'hE900_0000;

    int checks = 0;
    int failures = 0;
    int stalls = 0;
    logic acc_pv;
    logic [37:0] got_q[$];
    logic [37:0] exp_q[$];

    noc_packet_ejector dut (
        .noc_clk           (noc_clk),
        .noc_rst           (noc_rst),
        .receive_valid     (receive_valid),
        .receive_ready     (receive_ready),
        .receive_flit      (receive_flit),
        .receive_is_header (receive_is_header),
        .receive_is_tail   (receive_is_tail),
        .pkt_valid         (pkt_valid),
        .pkt_ready         (pkt_ready),
        .pkt_data          (pkt_data),
        .pkt_last          (pkt_last),
        .pkt_err           (pkt_err),
        .pkt_src_x         (pkt_src_x),
        .pkt_src_y         (pkt_src_y),
        .err_cnt           (err_cnt)
    );

    always #5 noc_clk = ~noc_clk;

    always @(negedge noc_clk) begin
        if (!noc_rst && pkt_valid && pkt_ready)
            got_q.push_back({pkt_data, pkt_last, pkt_err, pkt_src_x, pkt_src_y});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] ent(input logic [31:0] d, input logic l, input logic e);
        return {d, l, e, 2'd1, 2'd2};
    endfunction

    task automatic send(input logic [31:0] f, input logic h, input logic t);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        receive_valid = 1'b1;
        receive_flit = f;
        receive_is_header = h;
        receive_is_tail = t;
        while (!acc && n < 50) begin
            @(negedge noc_clk);
            acc = receive_ready;
            acc_pv = pkt_valid;
            @(posedge noc_clk);
            #2;
            if (!acc) begin
                n++;
                stalls++;
            end
        end
        if (!acc) chk("accept_timeout", 64'd1, 64'd0);
        receive_valid = 1'b0;
        receive_is_header = 1'b0;
        receive_is_tail = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge noc_clk);
        #2;
        noc_rst = 1'b1;
        receive_valid = 1'b0;
        @(negedge noc_clk);
        chk("rst_ready", 64'(receive_ready), 64'd0);
        chk("rst_pkt", {pkt_valid, pkt_last, pkt_err, pkt_src_x, pkt_src_y, pkt_data}, 64'd0);
        chk("rst_errcnt", 64'(err_cnt), 64'd0);
        repeat (2) @(posedge noc_clk);
        #2;
        noc_rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        stalls = 0;
        @(negedge noc_clk);
        chk("ready_after_rst", 64'(receive_ready), 64'd1);
        @(posedge noc_clk);
        #2;
    endtask

    task automatic check_q(input string tag);
        repeat (12) @(posedge noc_clk);
        #2;
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        do_reset();

        // good packet, three payload words
        pkt_ready = 1'b1;
        send(HDR, 1, 0);
        send(32'hA0A0_0001, 0, 0);
        send(32'hA0A0_0002, 0, 0);
        send(32'hA0A0_0003, 0, 0);
        send(TAIL, 0, 1);
        exp_q = '{ent(32'hA0A0_0001, 0, 0), ent(32'hA0A0_0002, 0, 0),
                  ent(32'hA0A0_0003, 1, 0)};
        check_q("good");
        chk("good_errcnt", 64'(err_cnt), 64'd0);

        // misrouted header is dropped through to its tail
        do_reset();
        send(HDR_BAD, 1, 0);
        send(32'hB0B0_0001, 0, 0);
        send(32'hB0B0_0002, 0, 0);
        send(TAIL, 0, 1);
        check_q("baddst");
        chk("baddst_stalls", 64'(stalls), 64'd0);
        chk("baddst_errcnt", 64'(err_cnt), 64'd1);

        // header in the middle of a packet aborts the staged word
        do_reset();
        send(HDR, 1, 0);
        send(32'hC0C0_0000, 0, 0);
        send(HDR, 1, 0);
        send(32'hC0C0_0001, 0, 0);
        send(TAIL, 0, 1);
        exp_q = '{ent(32'hC0C0_0000, 1, 1), ent(32'hC0C0_0001, 1, 0)};
        check_q("rehdr");
        chk("rehdr_errcnt", 64'(err_cnt), 64'd1);

        // backpressure: FIFO fills after four pushes
        do_reset();
        pkt_ready = 1'b0;
        send(HDR, 1, 0);
        for (int i = 0; i < 5; i++) send(32'hD0D0_0000 + 32'(i), 0, 0);
        receive_valid = 1'b1;
        receive_flit = 32'hD0D0_0005;
        @(negedge noc_clk);
        chk("full_ready", 64'(receive_ready), 64'd0);
        chk("full_head", {pkt_valid, pkt_last, pkt_data}, {2'b10, 32'hD0D0_0000});
        @(posedge noc_clk);
        #2;
        @(negedge noc_clk);
        chk("full_ready2", 64'(receive_ready), 64'd0);
        chk("full_stable", {pkt_valid, pkt_last, pkt_data}, {2'b10, 32'hD0D0_0000});
        @(posedge noc_clk);
        #2;
        pkt_ready = 1'b1;
        send(32'hD0D0_0005, 0, 0);
        send(TAIL, 0, 1);
        for (int i = 0; i < 6; i++) exp_q.push_back(ent(32'hD0D0_0000 + 32'(i), i == 5, 0));
        check_q("bp");

        // tail with the wrong source id
        do_reset();
        send(HDR, 1, 0);
        send(32'hE0E0_0000, 0, 0);
        send(TAIL_BAD, 0, 1);
        exp_q = '{ent(32'hE0E0_0000, 1, 1)};
        check_q("badtail");
        chk("badtail_errcnt", 64'(err_cnt), 64'd1);

        // reset mid-packet with a word already queued
        do_reset();
        pkt_ready = 1'b0;
        send(HDR, 1, 0);
        send(32'hF0F0_0000, 0, 0);
        send(32'hF0F0_0001, 0, 0);
        pkt_ready = 1'b1;
        do_reset();
        chk("midrst_empty", 64'(got_q.size()), 64'd0);
        send(HDR, 1, 0);
        send(32'hF0F0_0007, 0, 0);
        send(TAIL, 0, 1);
        chk("lat_early", 64'(acc_pv), 64'd0);
        @(negedge noc_clk);
        chk("lat_valid", 64'(pkt_valid), 64'd1);
        exp_q = '{ent(32'hF0F0_0007, 1, 0)};
        check_q("postrst");
        chk("postrst_errcnt", 64'(err_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_packet_ejector.md
NOC_PACKET_EJECTOR -- requirements
Module: noc_packet_ejector

Interface
REQ-001 SHALL have parameter X_ID, default 0, this node's X coordinate (`Noc_ID_X_Width bits).
REQ-002 SHALL have parameter Y_ID, default 0, this node's Y coordinate (`Noc_ID_Y_Width bits).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-004 SHALL use one clock and a synchronous, active-high reset:
- noc_clk  in  1  single clock; all state updates on its rising edge.
- noc_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have the following flit and packet ports:
- receive_valid  in  1  flit offered by the router local port.
- receive_ready  out  1  ejector accepts the offered flit.
- receive_flit  in  `Noc_Data_Width  flit.
- receive_is_header  in  1  flit is a header.
- receive_is_tail  in  1  flit is a tail.
- pkt_valid  out  1  payload word available.
- pkt_ready  in  1  consumer accepts the word.
- pkt_data  out  `Noc_Data_Width  payload flit.
- pkt_last  out  1  last payload word of the packet.
- pkt_err  out  1  packet was aborted or malformed; valid with pkt_last.
- pkt_src_x  out  `Noc_ID_X_Width  source X taken from the header.
- pkt_src_y  out  `Noc_ID_Y_Width  source Y taken from the header.
- err_cnt  out  8  saturating count of dropped or erroneous packets.

Function
REQ-006 A flit SHALL transfer only in a cycle where receive_valid and receive_ready are both 1; a pkt word SHALL transfer only where pkt_valid and pkt_ready are both 1.
REQ-007 The FSM SHALL have three states:
- IDLE: wait for a header.
- BODY: collect payload.
- DISCARD: drop flits until a tail.
REQ-008 A flit is a good header when all of the following hold:
- receive_is_header=1.
- Header H and E marker fields equal `Noc_Head_H and `Noc_Head_E.
- Destination field equals {X_ID,Y_ID}.
REQ-009 On a good header in IDLE, the block SHALL latch the source ID from bits [`Noc_Point_H-1:`Noc_Source_Point] and go to BODY.
REQ-010 Bad header in IDLE -> DISCARD, err_cnt+1.
REQ-011 Non-header flit in IDLE -> drop it, err_cnt+1, stay in IDLE.
REQ-012 BODY SHALL hold one staging register:
- Each accepted data flit pushes the previously staged flit (last=0), then is staged itself.
- The first data flit only fills the stage.
REQ-013 Tail in BODY SHALL be handled as follows:
- Push the staged flit with last=1.
- err=1 if the tail H/E markers do not equal `Noc_Tail_H/`Noc_Tail_E or the tail source does not equal the latched source; err=1 also increments err_cnt.
- Go to IDLE.
REQ-014 Tail in BODY with an empty stage (zero payload) SHALL push nothing, set err_cnt+1 and go to IDLE.
REQ-015 Header arriving in BODY SHALL:
- Push the staged flit (if any) with last=1 and err=1.
- Set err_cnt+1.
- Process the new header as in IDLE in the same cycle.
REQ-016 DISCARD SHALL keep receive_ready=1 and drop all flits; an accepted tail SHALL return the FSM to IDLE.
REQ-017 In IDLE/BODY, receive_ready SHALL be 1 when the FIFO is not full, and combinationally 0 when full unless a pop occurs in that cycle.
REQ-018 FIFO entry SHALL be {flit, last, err, src_x, src_y}; the FIFO SHALL be first-word-fall-through, with pkt_* driven directly from the head entry.
REQ-019 Push and pop in the same cycle SHALL both occur, count unchanged, including when full.
REQ-020 Latency SHALL be as follows:
- A payload flit SHALL appear on pkt_valid the cycle after its push.
- Single-data packet timing: header accepted cycle 0, data cycle 1, tail cycle 2 -> pkt_valid=1 in cycle 3.
REQ-021 pkt_valid and all pkt_* fields SHALL stay stable while pkt_valid=1 and pkt_ready=0.
REQ-022 err_cnt SHALL saturate at 255 and SHALL increment at most once per cycle.

Reset
REQ-023 While noc_rst=1, the following outputs SHALL be 0:
- receive_ready, pkt_valid, pkt_data, pkt_last, pkt_err, pkt_src_x, pkt_src_y, err_cnt.
REQ-024 Reset SHALL set the FSM to IDLE and empty the stage and FIFO.
REQ-025 After release, receive_ready SHALL be 1 in the first cycle.
REQ-026 Reset mid-packet SHALL discard the partial packet with no pkt output.

Structure
REQ-027 Field positions and marker constants SHALL come from the shared Noc_parameters include: `Noc_Head_H/E, `Noc_Tail_H/E, `Noc_Point_H, `Noc_Source_Point, `Axi_Len_Point, `Noc_Point_E.
REQ-028 State encodings SHALL be local parameters.
REQ-029 The FIFO SHALL be a sub-module noc_eject_fifo, parameterised by width and depth, with full/empty/count outputs.

Verification
REQ-030 Src (1,2) -> node (0,0): header, 3 data flits D0..D2, tail; pkt_ready=1 -> pkt words D0,D1,D2 with pkt_last only on D2, pkt_err=0, src=(1,2), err_cnt=0.
REQ-031 Header with destination (3,3) at node (0,0), then 2 data flits and a tail -> no pkt output, receive_ready stays 1, err_cnt=1.
REQ-032 Header, D0, then a new good header, D1, tail -> D0 with last=1,err=1, then D1 with last=1,err=0; err_cnt=1.
REQ-033 FIFO_DEPTH=4, pkt_ready=0, 6 data flits -> receive_ready drops after the 4th push; raise pkt_ready -> all 6 delivered in order.
REQ-034 Tail with a wrong source ID -> last word has pkt_err=1; err_cnt=1.
REQ-035 noc_rst pulsed after header+D0 -> all outputs 0; the next good packet is delivered normally.
